// File: rtl/cla_adder.sv
// Two-level carry-lookahead adder behind a capture/compute/present FSM.
// Operands are latched on request; the sum is registered one edge later.
module cla_adder #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             c_in,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             ready,
  output logic [WIDTH-1:0] Output,
  output logic             c_out
);

  localparam int NB = WIDTH / 4;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  state_t state_q, state_d;

  logic [WIDTH-1:0] a_q, b_q;
  logic             cin_q;

  logic [WIDTH-1:0] g, p, c, sum;
  logic [NB-1:0]    gg, gp;
  logic [NB:0]      cb;
  logic             t;

  // CLA: per-bit g/p, group G/P, second-level block carries, then sums
  always_comb begin
    g   = a_q & b_q;
    p   = a_q ^ b_q;
    gg  = '0;
    gp  = '0;
    cb  = '0;
    c   = '0;
    t   = 1'b0;
    for (int bi = 0; bi < NB; bi++) begin
      gg[bi] = g[4*bi+3]
             | (p[4*bi+3] & g[4*bi+2])
             | (p[4*bi+3] & p[4*bi+2] & g[4*bi+1])
             | (p[4*bi+3] & p[4*bi+2] & p[4*bi+1] & g[4*bi]);
      gp[bi] = &p[4*bi +: 4];
    end
    cb[0] = cin_q;
    for (int j = 1; j <= NB; j++) begin
      t = cin_q;
      for (int m = 0; m < j; m++) t = t & gp[m];
      cb[j] = t;
      for (int k = 0; k < j; k++) begin
        t = gg[k];
        for (int m = k + 1; m < j; m++) t = t & gp[m];
        cb[j] = cb[j] | t;
      end
    end
    for (int bi = 0; bi < NB; bi++) begin
      c[4*bi]   = cb[bi];
      c[4*bi+1] = g[4*bi]
                | (p[4*bi] & cb[bi]);
      c[4*bi+2] = g[4*bi+1]
                | (p[4*bi+1] & g[4*bi])
                | (p[4*bi+1] & p[4*bi] & cb[bi]);
      c[4*bi+3] = g[4*bi+2]
                | (p[4*bi+2] & g[4*bi+1])
                | (p[4*bi+2] & p[4*bi+1] & g[4*bi])
                | (p[4*bi+2] & p[4*bi+1] & p[4*bi] & cb[bi]);
    end
    sum = p ^ c;
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next state: one operation per en assertion
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (en) state_d = CALC;
      CALC:    state_d = DONE;
      DONE:    if (!en) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Operand capture in IDLE, result capture in CALC
  always_ff @(posedge clk) begin
    if (reset) begin
      a_q    <= '0;
      b_q    <= '0;
      cin_q  <= 1'b0;
      Output <= '0;
      c_out  <= 1'b0;
    end else begin
      if (state_q == IDLE && en) begin
        a_q   <= A;
        b_q   <= B;
        cin_q <= c_in;
      end
      if (state_q == CALC) begin
        Output <= sum;
        c_out  <= cb[NB];
      end
    end
  end

  assign ready = (state_q == DONE);

endmodule

// File: tb/tb_cla_adder.sv
// Bench for cla_adder: 4-bit and 8-bit instances driven in lockstep,
// table vectors, random vectors and reset/hold corner sequences.
module tb_cla_adder;

  logic       clk = 1'b0;
  logic       reset;
  logic       en;
  logic       c_in;
  logic [3:0] a4, b4;
  logic [7:0] a8, b8;
  logic       rdy4, rdy8;
  logic [3:0] out4;
  logic [7:0] out8;
  logic       co4, co8;

  int n_vec = 0;
  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic [4:0] e4;
    logic [8:0] e8;
  } vec_t;

  vec_t tbl[8];

  cla_adder #(.WIDTH(4)) dut4 (
    .clk(clk), .reset(reset), .en(en), .c_in(c_in),
    .A(a4), .B(b4), .ready(rdy4), .Output(out4), .c_out(co4)
  );

  cla_adder #(.WIDTH(8)) dut8 (
    .clk(clk), .reset(reset), .en(en), .c_in(c_in),
    .A(a8), .B(b8), .ready(rdy8), .Output(out8), .c_out(co8)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [8:0] act,
                     input logic [8:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic drive(input logic [7:0] a, input logic [7:0] b,
                       input logic cin);
    a4   = a[3:0];
    b4   = b[3:0];
    a8   = a;
    b8   = b;
    c_in = cin;
  endtask

  task automatic chk_res(input string nm, input logic [4:0] e4,
                         input logic [8:0] e8);
    chk({nm, " sum4"}, {4'd0, co4, out4}, {4'd0, e4});
    chk({nm, " sum8"}, {co8, out8}, e8);
  endtask

  task automatic chk_rdy(input string nm, input logic exp);
    chk({nm, " rdy4"}, {8'd0, rdy4}, {8'd0, exp});
    chk({nm, " rdy8"}, {8'd0, rdy8}, {8'd0, exp});
  endtask

  task automatic do_op(input string nm, input logic [7:0] a,
                       input logic [7:0] b, input logic cin,
                       input logic [4:0] e4, input logic [8:0] e8);
    @(negedge clk);
    drive(a, b, cin);
    en = 1'b1;
    @(negedge clk);
    chk_rdy({nm, " calc"}, 1'b0);
    drive(~a, ~b, ~cin);
    @(negedge clk);
    chk_rdy({nm, " done"}, 1'b1);
    chk_res({nm, " done"}, e4, e8);
    @(negedge clk);
    chk_rdy({nm, " hold"}, 1'b1);
    chk_res({nm, " hold"}, e4, e8);
    en = 1'b0;
    @(negedge clk);
    chk_rdy({nm, " idle"}, 1'b0);
    chk_res({nm, " idle"}, e4, e8);
    n_vec++;
  endtask

  initial begin
    logic [7:0] ra, rb;
    logic       rc;
    logic [4:0] m4;
    logic [8:0] m8;

    tbl[0] = '{8'd1,   8'd2,   1'b0, 5'd3,  9'd3};
    tbl[1] = '{8'd15,  8'd1,   1'b0, 5'd16, 9'd16};
    tbl[2] = '{8'd15,  8'd15,  1'b1, 5'd31, 9'd31};
    tbl[3] = '{8'd0,   8'd0,   1'b0, 5'd0,  9'd0};
    tbl[4] = '{8'd255, 8'd1,   1'b0, 5'd16, 9'd256};
    tbl[5] = '{8'd255, 8'd255, 1'b1, 5'd31, 9'd511};
    tbl[6] = '{8'd5,   8'd6,   1'b0, 5'd11, 9'd11};
    tbl[7] = '{8'h7A,  8'h86,  1'b0, 5'd16, 9'd256};

    reset = 1'b1;
    en    = 1'b0;
    drive(8'hA5, 8'h5A, 1'b1);
    repeat (2) @(negedge clk);
    chk_rdy("reset", 1'b0);
    chk_res("reset", 5'd0, 9'd0);
    reset = 1'b0;

    @(negedge clk);
    en = 1'b1;
    drive(8'd1, 8'd2, 1'b0);
    @(negedge clk);
    chk_rdy("first edge after reset", 1'b0);
    en = 1'b0;
    repeat (2) @(negedge clk);

    foreach (tbl[i])
      do_op($sformatf("tbl%0d", i), tbl[i].a, tbl[i].b,
            tbl[i].cin, tbl[i].e4, tbl[i].e8);

    for (int i = 0; i < 40; i++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      rc = 1'($urandom);
      m4 = 5'(ra[3:0]) + 5'(rb[3:0]) + 5'(rc);
      m8 = 9'(ra) + 9'(rb) + 9'(rc);
      do_op($sformatf("rnd%0d", i), ra, rb, rc, m4, m8);
    end

    do_op("pre-abort", 8'd9, 8'd9, 1'b1, 5'd19, 9'd19);
    @(negedge clk);
    drive(8'd5, 8'd6, 1'b0);
    en = 1'b1;
    @(negedge clk);
    reset = 1'b1;
    en    = 1'b0;
    @(negedge clk);
    chk_rdy("abort", 1'b0);
    chk_res("abort", 5'd0, 9'd0);
    reset = 1'b0;
    @(negedge clk);
    chk_rdy("abort idle", 1'b0);
    chk_res("abort idle", 5'd0, 9'd0);
    do_op("after abort", 8'd3, 8'd4, 1'b0, 5'd7, 9'd7);

    @(negedge clk);
    drive(8'd1, 8'd2, 1'b0);
    en = 1'b1;
    @(negedge clk);
    en = 1'b0;
    drive(8'd0, 8'd0, 1'b0);
    @(negedge clk);
    chk_rdy("pulse", 1'b1);
    chk_res("pulse", 5'd3, 9'd3);
    @(negedge clk);
    chk_rdy("pulse idle", 1'b0);
    n_vec++;

    @(negedge clk);
    drive(8'd2, 8'd2, 1'b0);
    en = 1'b1;
    repeat (6) @(negedge clk);
    chk_rdy("held en", 1'b1);
    drive(8'd9, 8'd9, 1'b0);
    @(negedge clk);
    chk_rdy("held en no rerun", 1'b1);
    chk_res("held en", 5'd4, 9'd4);
    en = 1'b0;
    repeat (3) @(negedge clk);
    chk_rdy("held en idle", 1'b0);
    chk_res("held en idle", 5'd4, 9'd4);
    n_vec++;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
